// File: rtl/alu_pkg.sv
// Shared definitions for the registered integer ALU: default width and opcode encodings.
package alu_pkg;

    localparam int unsigned WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_NEG = 3'b000,
        ALU_AND = 3'b001,
        ALU_XOR = 3'b010,
        ALU_OR  = 3'b011,
        ALU_DEC = 3'b100,
        ALU_ADD = 3'b101,
        ALU_SUB = 3'b110,
        ALU_INC = 3'b111
    } aluop_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage feeders (master) and the ALU (slave).
interface alu_if #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
);
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [2:0]       aluop;
    logic [WIDTH-1:0] alu_out;
    logic             add_sub_overflow;
    logic             zero;

    modport master (
        output operand1, operand2, aluop,
        input  alu_out, add_sub_overflow, zero
    );

    modport slave (
        input  operand1, operand2, aluop,
        output alu_out, add_sub_overflow, zero
    );
endinterface

// File: rtl/alu_addsub.sv
// Single shared adder: sum = x + (inv_y ? ~y : y) + cin, with signed overflow of that addition.
module alu_addsub #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             inv_y_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);
    logic [WIDTH-1:0] y_eff;

    // Optional inversion of Y turns the adder into a subtractor when paired with cin=1.
    always_comb begin
        y_eff = inv_y_i ? ~y_i : y_i;
        sum_o = x_i + y_eff + {{(WIDTH-1){1'b0}}, cin_i};
        // Operands agree in sign but the sum does not: signed overflow.
        ovf_o = (x_i[WIDTH-1] == y_eff[WIDTH-1]) && (sum_o[WIDTH-1] != x_i[WIDTH-1]);
    end
endmodule

// File: rtl/alu.sv
// Registered 32-bit signed ALU: eight ops, overflow for ADD/SUB, zero flag coherent with result.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    logic [WIDTH-1:0] as_x, as_y, as_sum;
    logic             as_inv, as_cin, as_ovf;

    logic [WIDTH-1:0] alu_out_d, alu_out_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x_i     (as_x),
        .y_i     (as_y),
        .inv_y_i (as_inv),
        .cin_i   (as_cin),
        .sum_o   (as_sum),
        .ovf_o   (as_ovf)
    );

    // Map each arithmetic opcode onto the shared adder's operands.
    always_comb begin
        as_x   = bus.operand1;
        as_y   = bus.operand2;
        as_inv = 1'b0;
        as_cin = 1'b0;
        case (bus.aluop)
            ALU_NEG: begin as_x = '0; as_y = bus.operand1; as_inv = 1'b1; as_cin = 1'b1; end
            ALU_DEC: begin as_y = '1; end
            ALU_INC: begin as_y = '0; as_cin = 1'b1; end
            ALU_SUB: begin as_inv = 1'b1; as_cin = 1'b1; end
            default: ;
        endcase
    end

    // Result mux; overflow only reported for ADD/SUB, zero derived from next-state result.
    always_comb begin
        alu_out_d = as_sum;
        ovf_d     = 1'b0;
        case (bus.aluop)
            ALU_AND: alu_out_d = bus.operand1 & bus.operand2;
            ALU_XOR: alu_out_d = bus.operand1 ^ bus.operand2;
            ALU_OR:  alu_out_d = bus.operand1 | bus.operand2;
            ALU_ADD,
            ALU_SUB: ovf_d     = as_ovf;
            default: ;
        endcase
        zero_d = (alu_out_d == '0);
    end

    // Output registers with asynchronous clear to result 0, no overflow, zero set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            alu_out_q <= alu_out_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.alu_out          = alu_out_q;
    assign bus.add_sub_overflow = ovf_q;
    assign bus.zero             = zero_q;
endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
module tb_alu;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_out,
                              input logic e_ovf, input logic e_zero);
        check({tag, ".out"},  bus.alu_out, e_out);
        check({tag, ".ovf"},  {31'd0, bus.add_sub_overflow}, {31'd0, e_ovf});
        check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, e_zero});
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.operand1 = a;
        bus.operand2 = b;
        bus.aluop    = op;
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] e_out,
                         input logic e_ovf, input logic e_zero);
        drive(a, b, op);
        @(posedge clk);
        #1;
        check_outs(tag, e_out, e_ovf, e_zero);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        drive(32'd0, 32'd0, 3'b000);

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_outs("reset_async", 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1 check_outs("reset_hold", 32'h0, 1'b0, 1'b1);
        #2 rst_n = 1'b1;

        // Operation sweep with A=32, B=34.
        do_op("neg",  32'd32, 32'd34, 3'b000, 32'hFFFFFFE0, 1'b0, 1'b0);
        do_op("and",  32'd32, 32'd34, 3'b001, 32'h00000020, 1'b0, 1'b0);
        do_op("xor",  32'd32, 32'd34, 3'b010, 32'h00000002, 1'b0, 1'b0);
        do_op("or",   32'd32, 32'd34, 3'b011, 32'h00000022, 1'b0, 1'b0);
        do_op("dec",  32'd32, 32'd34, 3'b100, 32'h0000001F, 1'b0, 1'b0);
        do_op("add",  32'd32, 32'd34, 3'b101, 32'h00000042, 1'b0, 1'b0);
        do_op("sub",  32'd32, 32'd34, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("inc",  32'd32, 32'd34, 3'b111, 32'h00000021, 1'b0, 1'b0);

        // Overflow boundaries.
        do_op("add_ovf_pos", 32'h7FFFFFFF, 32'h00000001, 3'b101, 32'h80000000, 1'b1, 1'b0);
        do_op("add_ovf_neg", 32'h80000000, 32'h80000000, 3'b101, 32'h00000000, 1'b1, 1'b1);
        do_op("sub_ovf_pos", 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h80000000, 1'b1, 1'b0);
        do_op("sub_ovf_neg", 32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b1, 1'b0);
        do_op("add_noovf",   32'hFFFFFFFF, 32'h00000001, 3'b101, 32'h00000000, 1'b0, 1'b1);

        // Wrapping unary ops never flag overflow.
        do_op("neg_min",  32'h80000000, 32'h0, 3'b000, 32'h80000000, 1'b0, 1'b0);
        do_op("inc_wrap", 32'hFFFFFFFF, 32'h0, 3'b111, 32'h00000000, 1'b0, 1'b1);
        do_op("inc_max",  32'h7FFFFFFF, 32'h0, 3'b111, 32'h80000000, 1'b0, 1'b0);
        do_op("dec_min",  32'h80000000, 32'h0, 3'b100, 32'h7FFFFFFF, 1'b0, 1'b0);

        // Zero flag from various ops.
        do_op("sub_zero", 32'd5, 32'd5, 3'b110, 32'h00000000, 1'b0, 1'b1);
        do_op("xor_zero", 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b010, 32'h00000000, 1'b0, 1'b1);
        do_op("and_zero", 32'hFFFFFFFF, 32'h00000000, 3'b001, 32'h00000000, 1'b0, 1'b1);
        do_op("or_mix",   32'hF0F00000, 32'h0000F0F0, 3'b011, 32'hF0F0F0F0, 1'b0, 1'b0);
        do_op("neg_one",  32'h00000001, 32'h0, 3'b000, 32'hFFFFFFFF, 1'b0, 1'b0);

        // Reset asserted mid-cycle during ADD traffic.
        do_op("pre_rst_add", 32'd1, 32'd2, 3'b101, 32'h00000003, 1'b0, 1'b0);
        drive(32'h7FFFFFFF, 32'h00000001, 3'b101);
        #3 rst_n = 1'b0;
        #1 check_outs("mid_rst_clear", 32'h0, 1'b0, 1'b1);
        drive(32'd10, 32'd20, 3'b101);
        @(posedge clk);
        #1 check_outs("mid_rst_hold", 32'h0, 1'b0, 1'b1);
        #3 rst_n = 1'b1;
        #1 check_outs("rst_release", 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1 check_outs("post_rst_add", 32'h0000001E, 1'b0, 1'b0);
        do_op("post_rst_ovf", 32'h7FFFFFFF, 32'h00000001, 3'b101, 32'h80000000, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
